stop_watch_bcd_n: RTL and testbench
===================================

// Module: stop_watch_bcd_n
// PURPOSE
//  Parametrised N-digit BCD stopwatch/timer: prescaler divides clk to a count tick, which
//  drives a cascaded chain of BCD digits counting up or down. Adds lap-hold display capture,
//  sticky overflow flag and down-count terminal detect. Feeds the 7-seg mux/hex driver layer.
// PARAMETERS
//  DIGITS   4          number of BCD digits (1..8); d[3:0] is least significant
//  DVSR     5_000_000  clk cycles per count tick (>=2); 5e6 @50 MHz = 0.1 s
//  PW       $clog2(DVSR) prescaler width (localparam, not overridable)
// PORTS
//  clk      in   1          system clock, all state on rising edge
//  reset_n  in   1          asynchronous active-low reset
//  go       in   1          level: 1 = run, 0 = pause (state frozen)
//  clr      in   1          sync clear pulse/level
//  up       in   1          1 = count up, 0 = count down
//  load     in   1          sync load of preset value into digits
//  preset   in   4*DIGITS   BCD value loaded on load
//  lap      in   1          single-cycle pulse from debouncer; toggles display hold
//  d        out  4*DIGITS   displayed BCD value (live or held)
//  tick     out  1          1-cycle pulse, high in the cycle the new count first appears
//  ovf      out  1          sticky: up-count wrapped max->0
//  zero     out  1          level: live count == 0 while up=0
//  held     out  1          level: display is showing captured lap value
// BEHAVIOUR
//  Reset (reset_n=0, async): prescaler, digits, lap register = 0; d=0, tick=0, ovf=0,
//   held=0; zero=1 only if up=0 (combinational from live count).
//  Priority per edge: clr > load > count. clr: prescaler, digits, ovf, held cleared.
//   load: digits <= preset, prescaler <= 0, ovf unchanged; held unaffected.
//  Prescaler: runs 0..DVSR-1 while go=1 and not halted; held when go=0; wraps to 0 at
//   DVSR-1 asserting internal en for that cycle. Digits update on the same edge.
//  Halt: up=0 and live count all-zero -> prescaler and digits hold regardless of go.
//  Up cascade: digit i increments on en when digits 0..i-1 are all 9; 9 -> 0. All digits 9
//   on en -> all 0 and ovf <= 1 (sticky until clr or reset).
//  Down cascade: digit i decrements on en when digits 0..i-1 are all 0; 0 -> 9. Never wraps
//   below zero (halt rule). up may change any cycle; applies at next en; prescaler keeps phase.
//  preset digit >9: loaded digit is forced to 9 (saturate); other digits load as given.
//  tick: registered copy of en (one cycle after prescaler wrap edge = new count visible).
//  Lap: lap pulse with held=0 -> capture live count into lap register, held<=1; lap with
//   held=1 -> held<=0. d = held ? lap register : live count. Counting never stops for lap.
//   lap coincident with clr: clr wins, held=0. lap coincident with en: captures pre-update value.
//  Widths: all arithmetic per 4-bit digit; no binary-to-BCD conversion anywhere.
// STRUCTURE
//  Shared package stopwatch_pkg: BCD_W=4, BCD_MAX=4'd9, BCD_ZERO=4'd0, digit typedef
//   bcd_t [3:0]; reused by hex/7-seg display blocks.
//  Sub-module bcd_digit_cnt (one digit): in clk, reset_n, clr, load, ld_val, en, up;
//   out q, is_max, is_min. Top instantiates DIGITS copies via generate; carry-enable chain
//   and prescaler, lap register, flags live in top.
// TESTING  (bench uses DIGITS=3, DVSR=4)
//  1 reset_n low mid-run, go=1 -> d=000, tick=0, ovf=0, held=0 immediately (async).
//  2 go=1 up=1 from 000, 40 clk -> d=010, exactly 10 tick pulses, each 4 clk apart.
//  3 load preset=998, up=1 go=1, 8 clk -> d 999 then 000, ovf=1 stays 1; clr -> ovf=0, d=000.
//  4 load preset=012 up=0 go=1 -> counts 011..000, zero=1, d holds 000, no tick after 000.
//  5 run up, lap at d=023 -> held=1, d=023 while live advances; second lap at live 030
//   -> held=0, d=030; pulse go=0 for 10 clk -> d and prescaler frozen.
//  6 clr and load same cycle, preset=555 -> d=000; load preset=A05 -> d=905.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared BCD digit types and constants for the stopwatch and the display blocks.
// Also provides the helper that clamps an out-of-range digit to 9.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  // Digit codes A..F are not valid BCD; they load as 9.
  function automatic bcd_t bcd_sat(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit: up/down counter that wraps 9->0 on increment and 0->9 on decrement.
// Update priority is clr > load > en.
module bcd_digit_cnt
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic load,
  input  bcd_t ld_val,
  input  logic en,
  input  logic up,
  output bcd_t q,
  output logic is_max,
  output logic is_min
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= BCD_ZERO;
    end else if (clr) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= bcd_sat(ld_val);
    end else if (en) begin
      if (up) q <= (q == BCD_MAX)  ? BCD_ZERO : q + 4'd1;
      else    q <= (q == BCD_ZERO) ? BCD_MAX  : q - 4'd1;
    end
  end

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == BCD_ZERO);

endmodule

// File: rtl/stop_watch_bcd_n.sv
// N-digit BCD stopwatch: prescaler tick drives a carry/borrow chain of BCD digits,
// with lap hold of the displayed value, sticky overflow and down-count zero halt.
module stop_watch_bcd_n
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DVSR   = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   d,
  output logic                  tick,
  output logic                  ovf,
  output logic                  zero,
  output logic                  held
);

  localparam int PW = $clog2(DVSR);

  logic [PW-1:0]       pre_cnt;
  logic [4*DIGITS-1:0] live_cnt;
  logic [4*DIGITS-1:0] lap_q;
  logic [DIGITS-1:0]   is_max, is_min, dig_en;
  logic                halt, run, wrap, en;

  // Counting down stops at all-zero; the prescaler freezes too so no tick follows.
  assign halt = !up && (&is_min);
  assign run  = go && !halt;
  assign wrap = (pre_cnt == PW'(DVSR - 1));
  assign en   = run && wrap && !clr && !load;
  assign zero = halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (clr || load) begin
      pre_cnt <= '0;
    end else if (run) begin
      pre_cnt <= wrap ? '0 : pre_cnt + PW'(1);
    end
  end

  // Digit i steps when every lower digit is at its roll-over value for the direction.
  always_comb begin : carry_chain
    logic c;
    dig_en = '0;
    c      = en;
    for (int i = 0; i < DIGITS; i++) begin
      dig_en[i] = c;
      c         = c && (up ? is_max[i] : is_min[i]);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_cnt u_dig (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (clr),
      .load   (load),
      .ld_val (preset[4*i +: 4]),
      .en     (dig_en[i]),
      .up     (up),
      .q      (live_cnt[4*i +: 4]),
      .is_max (is_max[i]),
      .is_min (is_min[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tick <= en;
      if (clr)                    ovf <= 1'b0;
      else if (en && up && &is_max) ovf <= 1'b1;
    end
  end

  // Lap capture samples the live count before any same-edge update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= '0;
      held  <= 1'b0;
    end else if (clr) begin
      held  <= 1'b0;
    end else if (lap) begin
      if (!held) lap_q <= live_cnt;
      held <= !held;
    end
  end

  assign d = held ? lap_q : live_cnt;

endmodule

// File: tb/tb_stop_watch_bcd_n.sv
// Directed bench for stop_watch_bcd_n with DIGITS=3, DVSR=4 (one count every 4 clocks).
// Inputs change at the falling edge; outputs are sampled at the falling edge.
module tb_stop_watch_bcd_n;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, clr, up, load, lap;
  logic [11:0] preset;
  logic [11:0] d;
  logic        tick, ovf, zero, held;

  int errors = 0;
  int checks = 0;

  stop_watch_bcd_n #(.DIGITS(3), .DVSR(4)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .clr(clr), .up(up), .load(load),
    .preset(preset), .lap(lap), .d(d), .tick(tick), .ovf(ovf), .zero(zero), .held(held)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pulse();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; go = 0; clr = 0; up = 0; load = 0; lap = 0; preset = '0;
    #1;
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL reset_d actual=%h required=000", d); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero_down actual=%b required=1", zero); end
    step(2);
    reset_n = 1'b1;
    up = 1; go = 1;
    step(10);
    checks++; if (d !== 12'h002) begin errors++; $display("FAIL prereset_d actual=%h required=002", d); end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL async_reset_d actual=%h required=000", d); end
    checks++; if ({tick, ovf, held} !== 3'b000) begin errors++; $display("FAIL async_reset_flags actual=%b required=000", {tick, ovf, held}); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL async_reset_zero_up actual=%b required=0", zero); end
    go = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    int ntick, last, bad;
    ntick = 0; last = 0; bad = 0;
    clear_pulse();
    go = 1; up = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (ntick > 0 && c - last != 4) bad++;
        last = c;
        ntick++;
      end
    end
    go = 0;
    checks++; if (d !== 12'h010) begin errors++; $display("FAIL up40_d actual=%h required=010", d); end
    checks++; if (ntick != 10) begin errors++; $display("FAIL up40_ticks actual=%0d required=10", ntick); end
    checks++; if (bad != 0) begin errors++; $display("FAIL tick_spacing bad_gaps=%0d required=0", bad); end
  endtask

  task automatic test_overflow();
    up = 1; go = 1; load = 1; preset = 12'h998;
    step(1);
    load = 0;
    step(4);
    checks++; if (d !== 12'h999 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_999 actual=%h/%b required=999/0", d, ovf); end
    step(4);
    checks++; if (d !== 12'h000 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrap actual=%h/%b required=000/1", d, ovf); end
    step(4);
    checks++; if (d !== 12'h001 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%h/%b required=001/1", d, ovf); end
    clear_pulse();
    checks++; if (d !== 12'h000 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr actual=%h/%b required=000/0", d, ovf); end
    go = 0;
  endtask

  task automatic test_count_down();
    int ntick;
    ntick = 0;
    up = 0; go = 1; load = 1; preset = 12'h012;
    step(1);
    load = 0;
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL down_zero_early actual=%b required=0", zero); end
    step(4);
    checks++; if (d !== 12'h011) begin errors++; $display("FAIL down_011 actual=%h required=011", d); end
    step(8);
    checks++; if (d !== 12'h009) begin errors++; $display("FAIL down_borrow actual=%h required=009", d); end
    step(36);
    checks++; if (d !== 12'h000 || zero !== 1'b1) begin errors++; $display("FAIL down_000 actual=%h/%b required=000/1", d, zero); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tick === 1'b1) ntick++;
    end
    checks++; if (ntick != 0) begin errors++; $display("FAIL down_halt_ticks actual=%0d required=0", ntick); end
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL down_hold actual=%h required=000", d); end
    go = 0; up = 1;
    #1;
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL zero_up actual=%b required=0", zero); end
  endtask

  task automatic test_lap_pause();
    clear_pulse();
    up = 1; go = 1;
    step(92);
    checks++; if (d !== 12'h023) begin errors++; $display("FAIL lap_pre actual=%h required=023", d); end
    lap = 1; step(1); lap = 0;
    checks++; if (d !== 12'h023 || held !== 1'b1) begin errors++; $display("FAIL lap_hold actual=%h/%b required=023/1", d, held); end
    step(27);
    checks++; if (d !== 12'h023 || held !== 1'b1) begin errors++; $display("FAIL lap_frozen actual=%h/%b required=023/1", d, held); end
    lap = 1; step(1); lap = 0;
    checks++; if (d !== 12'h030 || held !== 1'b0) begin errors++; $display("FAIL lap_release actual=%h/%b required=030/0", d, held); end
    go = 0;
    step(10);
    checks++; if (d !== 12'h030) begin errors++; $display("FAIL pause_d actual=%h required=030", d); end
    go = 1;
    step(2);
    checks++; if (d !== 12'h030) begin errors++; $display("FAIL pause_phase_a actual=%h required=030", d); end
    step(1);
    checks++; if (d !== 12'h031) begin errors++; $display("FAIL pause_phase_b actual=%h required=031", d); end
    go = 0;
  endtask

  task automatic test_clr_load();
    go = 0;
    clr = 1; load = 1; preset = 12'h555;
    step(1);
    clr = 0; load = 0;
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL clr_over_load actual=%h required=000", d); end
    load = 1; preset = 12'hA05; step(1); load = 0;
    checks++; if (d !== 12'h905) begin errors++; $display("FAIL load_sat actual=%h required=905", d); end
    lap = 1; step(1); lap = 0;
    load = 1; preset = 12'h123; step(1); load = 0;
    checks++; if (d !== 12'h905 || held !== 1'b1) begin errors++; $display("FAIL load_keeps_held actual=%h/%b required=905/1", d, held); end
    clr = 1; lap = 1; step(1); clr = 0; lap = 0;
    checks++; if (d !== 12'h000 || held !== 1'b0) begin errors++; $display("FAIL clr_over_lap actual=%h/%b required=000/0", d, held); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_overflow();
    test_count_down();
    test_lap_pause();
    test_clr_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
